pc_unit: RTL and testbench

Parametrised program-counter unit for the fetch stage, replacing the fixed 32-bit increment/load counter. It holds the fetch address, advances by a configurable step and takes prioritised redirects: reset, exception, branch/jump, and an optional return-address stack (RAS) pop. It also supports stall-hold and a small circular RAS for call/return prediction, and drives the instruction-memory address directly.

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_ras.sv | 78 +++++++
 rtl/pc_unit.sv | 142 ++++++++++++++
 tb/tb_pc_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter unit.
//   pc_sel_e        : next-PC source select, in descending priority order
//   PC_RESET_VEC    : default PC after reset
//   PC_EXC_VEC      : default exception entry point (truncated to the PC width by users)
//   PC_STEP         : default sequential increment in bytes
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEL_RESET,
    PC_SEL_EXC,
    PC_SEL_HOLD,
    PC_SEL_REDIR,
    PC_SEL_RAS,
    PC_SEL_SEQ
  } pc_sel_e;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VEC   = 32'h0000_0180;
  localparam int unsigned PC_STEP      = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack for call/return prediction.
//   clk_i        : clock, all state on the rising edge
//   rst_ni       : synchronous active-low reset, clears pointer, count and all entries
//   push_i       : write push_data_i above the current top (overwrites oldest when full)
//   pop_i        : drop the top entry (ignored when empty)
//   replace_i    : overwrite the top entry in place, count unchanged
//   clear_i      : empty the stack (count to zero), takes priority over other requests
//   push_data_i  : data for push/replace
//   top_o        : entry at the stack pointer
//   empty_o      : no valid entries
//   full_o       : DEPTH valid entries
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             replace_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (push_i) begin
      // Pointer wraps naturally, so a push into a full stack lands on the oldest entry.
      ptr_d        = ptr_q + 1'b1;
      mem_d[ptr_d] = push_data_i;
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (replace_i) begin
      mem_d[ptr_q] = push_data_i;
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign top_o   = mem_q[ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntMax);

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised redirects and optional return-address stack.
// Build option: define PC_RAS_EN to instantiate the RAS; otherwise call/ret are ignored and
// the RAS outputs are tied to their reset values.
//   clk             : clock, all state on the rising edge
//   clr_n           : synchronous active-low reset
//   stall           : hold PC, RAS and underflow flag
//   exc             : load EXC_VEC, clear RAS (overrides stall)
//   redirect_valid  : taken branch/jump to redirect_target
//   redirect_target : redirect address, used as-is
//   call            : redirect is a call, push pc_out + STEP
//   ret             : return, next PC from RAS top
//   pc_out          : registered fetch address
//   ras_top         : current RAS top entry
//   ras_empty       : RAS holds no entries
//   ras_full        : RAS holds RAS_DEPTH entries
//   ras_underflow   : sticky, set by a ret against an empty RAS
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      STEP      = PC_STEP,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC),
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             stall,
  input  logic             exc,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow
);

  pc_sel_e          sel;
  logic [WIDTH-1:0] pc_q, pc_d, pc_seq;
  logic [WIDTH-1:0] ras_top_int;
  logic             ras_hit;

  assign pc_seq = pc_q + WIDTH'(STEP);

`ifdef PC_RAS_EN
  logic ras_empty_int, ras_full_int;
  logic ras_active, ras_push, ras_pop, ras_replace;
  logic underflow_q, underflow_d;

  // Call/ret only act in a cycle that is neither stalled nor taking an exception.
  assign ras_active  = ~stall & ~exc;
  assign ras_hit     = ret & ~redirect_valid & ~ras_empty_int;
  assign ras_push    = ras_active & redirect_valid & call;
  assign ras_pop     = ras_active & ras_hit & ~call;
  // call+ret without redirect: return through the top and leave the new return address there.
  assign ras_replace = ras_active & ras_hit & call;
  assign underflow_d = underflow_q | (ras_active & ret & ~redirect_valid & ras_empty_int);

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk),
    .rst_ni      (clr_n),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .replace_i   (ras_replace),
    .clear_i     (exc),
    .push_data_i (pc_seq),
    .top_o       (ras_top_int),
    .empty_o     (ras_empty_int),
    .full_o      (ras_full_int)
  );

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

  assign ras_top       = ras_top_int;
  assign ras_empty     = ras_empty_int;
  assign ras_full      = ras_full_int;
  assign ras_underflow = underflow_q;
`else
  logic        unused_ras_inputs;
  logic [31:0] unused_ras_depth;

  assign unused_ras_inputs = call ^ ret;
  assign unused_ras_depth  = RAS_DEPTH;
  assign ras_hit           = 1'b0;
  assign ras_top_int       = '0;
  assign ras_top           = '0;
  assign ras_empty         = 1'b1;
  assign ras_full          = 1'b0;
  assign ras_underflow     = 1'b0;
`endif

  always_comb begin
    sel = PC_SEL_SEQ;
    if (!clr_n) begin
      sel = PC_SEL_RESET;
    end else if (exc) begin
      sel = PC_SEL_EXC;
    end else if (stall) begin
      sel = PC_SEL_HOLD;
    end else if (redirect_valid) begin
      sel = PC_SEL_REDIR;
    end else if (ras_hit) begin
      sel = PC_SEL_RAS;
    end
  end

  always_comb begin
    pc_d = pc_seq;
    unique case (sel)
      PC_SEL_RESET: pc_d = RESET_VEC;
      PC_SEL_EXC:   pc_d = EXC_VEC;
      PC_SEL_HOLD:  pc_d = pc_q;
      PC_SEL_REDIR: pc_d = redirect_target;
      PC_SEL_RAS:   pc_d = ras_top_int;
      PC_SEL_SEQ:   pc_d = pc_seq;
      default:      pc_d = pc_seq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_out = pc_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit instance plus an 8-bit instance for wrap-around,
// both driven by the same controls.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        stall, exc, redirect_valid, call, ret;
  logic [31:0] redirect_target;
  logic [7:0]  rt8;

  logic [31:0] pc_out, ras_top;
  logic        ras_empty, ras_full, ras_underflow;
  logic [7:0]  pc8, top8;
  logic        empty8, full8, uf8;

  int vectors = 0;
  int miscompares = 0;

  assign rt8 = redirect_target[7:0];

  always #5 clk = ~clk;

  pc_unit dut (
    .clk             (clk),
    .clr_n           (clr_n),
    .stall           (stall),
    .exc             (exc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .call            (call),
    .ret             (ret),
    .pc_out          (pc_out),
    .ras_top         (ras_top),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full),
    .ras_underflow   (ras_underflow)
  );

  pc_unit #(
    .WIDTH     (8),
    .RESET_VEC (8'hF8)
  ) dut8 (
    .clk             (clk),
    .clr_n           (clr_n),
    .stall           (stall),
    .exc             (exc),
    .redirect_valid  (redirect_valid),
    .redirect_target (rt8),
    .call            (call),
    .ret             (ret),
    .pc_out          (pc8),
    .ras_top         (top8),
    .ras_empty       (empty8),
    .ras_full        (full8),
    .ras_underflow   (uf8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [31:0] tgt, input logic c, input logic r,
                       input logic s, input logic e);
    redirect_valid  = rv;
    redirect_target = tgt;
    call            = c;
    ret             = r;
    stall           = s;
    exc             = e;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] tgt;
    logic [31:0] rets [4];
    rets[0] = 32'h44;
    rets[1] = 32'h34;
    rets[2] = 32'h24;
    rets[3] = 32'h14;

    clr_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("rst_pc", pc_out, 32'h0);
    check("rst_pc8", {24'h0, pc8}, 32'hF8);
    check("rst_empty", {31'h0, ras_empty}, 32'h1);
    check("rst_full", {31'h0, ras_full}, 32'h0);
    check("rst_uf", {31'h0, ras_underflow}, 32'h0);
    check("rst_top", ras_top, 32'h0);

    // Free-running sequence and 8-bit wrap.
    clr_n = 1'b1;
    tick();
    check("seq1", pc_out, 32'h4);
    check("seq1_8", {24'h0, pc8}, 32'hFC);
    tick();
    check("seq2", pc_out, 32'h8);
    check("wrap8", {24'h0, pc8}, 32'h00);
    tick();
    check("seq3", pc_out, 32'hC);
    check("seq3_8", {24'h0, pc8}, 32'h04);

    drive(1, 32'h10, 0, 0, 0, 0);
    tick();
    check("redir", pc_out, 32'h10);
    check("redir8", {24'h0, pc8}, 32'h10);

    // Stall beats redirect.
    drive(1, 32'h999, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", pc_out, 32'h10);
    end
    check("stall_empty", {31'h0, ras_empty}, 32'h1);

    // Exception beats stall.
    drive(1, 32'h999, 0, 0, 1, 1);
    tick();
    check("exc", pc_out, 32'h180);
    check("exc8", {24'h0, pc8}, 32'h80);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("post_exc", pc_out, 32'h184);

`ifdef PC_RAS_EN
    drive(1, 32'h20, 0, 0, 0, 0);
    tick();
    check("to20", pc_out, 32'h20);
    drive(1, 32'h100, 1, 0, 0, 0);
    tick();
    check("call_pc", pc_out, 32'h100);
    check("call_empty", {31'h0, ras_empty}, 32'h0);
    check("call_top", ras_top, 32'h24);
    drive(0, 0, 0, 1, 0, 0);
    tick();
    check("ret_pc", pc_out, 32'h24);
    check("ret_empty", {31'h0, ras_empty}, 32'h1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("ret_seq", pc_out, 32'h28);

    // Five calls into a 4-deep stack: oldest return (0x4) is overwritten.
    drive(1, 32'h0, 0, 0, 0, 0);
    tick();
    check("to0", pc_out, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      tgt = (i == 5) ? 32'h300 : 32'(i * 16);
      drive(1, tgt, 1, 0, 0, 0);
      tick();
      check("call5_pc", pc_out, tgt);
      if (i == 4) check("full4", {31'h0, ras_full}, 32'h1);
    end
    check("full5", {31'h0, ras_full}, 32'h1);
    check("top5", ras_top, 32'h44);
    drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ret5_pc", pc_out, rets[i]);
    end
    check("ret5_empty", {31'h0, ras_empty}, 32'h1);
    check("ret5_uf0", {31'h0, ras_underflow}, 32'h0);
    tick();
    check("uf_seq", pc_out, 32'h18);
    check("uf_set", {31'h0, ras_underflow}, 32'h1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("uf_sticky_pc", pc_out, 32'h1C);
    check("uf_sticky", {31'h0, ras_underflow}, 32'h1);

    // Redirect wins over ret; RAS untouched.
    drive(1, 32'h200, 1, 0, 0, 0);
    tick();
    check("call200", pc_out, 32'h200);
    drive(1, 32'h300, 0, 1, 0, 0);
    tick();
    check("redir_ret_pc", pc_out, 32'h300);
    check("redir_ret_top", ras_top, 32'h20);
    check("redir_ret_empty", {31'h0, ras_empty}, 32'h0);

    // call+ret without redirect at 0x50 with top 0x200.
    drive(1, 32'h1FC, 0, 0, 0, 0);
    tick();
    drive(1, 32'h50, 1, 0, 0, 0);
    tick();
    check("at50", pc_out, 32'h50);
    check("top200", ras_top, 32'h200);
    drive(0, 0, 1, 1, 0, 0);
    tick();
    check("cr_pc", pc_out, 32'h200);
    check("cr_top", ras_top, 32'h54);
    drive(0, 0, 0, 1, 0, 0);
    tick();
    check("cr_ret1", pc_out, 32'h54);
    check("cr_top1", ras_top, 32'h20);
    tick();
    check("cr_ret2", pc_out, 32'h20);
    check("cr_empty", {31'h0, ras_empty}, 32'h1);

    // Stall ignores ret.
    drive(1, 32'h40, 1, 0, 0, 0);
    tick();
    check("push24_top", ras_top, 32'h24);
    drive(0, 0, 0, 1, 1, 0);
    tick();
    check("stall_ret_pc", pc_out, 32'h40);
    check("stall_ret_empty", {31'h0, ras_empty}, 32'h0);

    // Exception clears RAS and discards the push; underflow survives.
    drive(1, 32'h500, 1, 0, 0, 1);
    tick();
    check("exc_clr_pc", pc_out, 32'h180);
    check("exc_clr_empty", {31'h0, ras_empty}, 32'h1);
    check("exc_uf", {31'h0, ras_underflow}, 32'h1);

    // Reset during a push cycle.
    drive(1, 32'h700, 1, 0, 0, 0);
    tick();
    check("push700_empty", {31'h0, ras_empty}, 32'h0);
    clr_n = 1'b0;
    drive(1, 32'h600, 1, 0, 0, 0);
    tick();
    check("rst_push_pc", pc_out, 32'h0);
    check("rst_push_empty", {31'h0, ras_empty}, 32'h1);
    check("rst_push_top", ras_top, 32'h0);
    check("rst_push_uf", {31'h0, ras_underflow}, 32'h0);
    clr_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("rst_push_seq", pc_out, 32'h4);
`else
    drive(1, 32'h8, 0, 0, 0, 0);
    tick();
    check("to8", pc_out, 32'h8);
    drive(0, 0, 0, 1, 0, 0);
    tick();
    check("noras_ret", pc_out, 32'hC);
    check("noras_uf", {31'h0, ras_underflow}, 32'h0);
    check("noras_empty", {31'h0, ras_empty}, 32'h1);
    drive(1, 32'h100, 1, 0, 0, 0);
    tick();
    check("noras_call", pc_out, 32'h100);
    check("noras_top", ras_top, 32'h0);
    check("noras_full", {31'h0, ras_full}, 32'h0);
    drive(0, 0, 1, 1, 0, 0);
    tick();
    check("noras_cr", pc_out, 32'h104);
    clr_n = 1'b0;
    drive(1, 32'h600, 1, 0, 0, 0);
    tick();
    check("noras_rst", pc_out, 32'h0);
    clr_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("noras_rst_seq", pc_out, 32'h4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
